// File: rtl/clock_time_keeper.sv
`default_nettype none
// ============================================================================
// Module      : clock_time_keeper
// Description : 24-hour HH:MM:SS timekeeper clocked at 1 kHz. Two debounced
//               push-buttons (mode, inc) step through RUN -> SET_HOUR ->
//               SET_MIN -> RUN and increment the selected field.
//               Optional feature macro: HOURLY_CHIME_EN adds the chime port
//               and its pulse-length counter.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_time_keeper #(
  parameter int TICKS_PER_SEC  = 1000,
  parameter int DEBOUNCE_TICKS = 20
`ifdef HOURLY_CHIME_EN
  ,
  parameter int CHIME_TICKS    = 500
`endif
) (
  input  logic       clk_1000hz,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] hour,
  output logic [1:0] set_state,
  output logic       tick_1hz
`ifdef HOURLY_CHIME_EN
  ,
  output logic       chime
`endif
);

  localparam int c_PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(TICKS_PER_SEC - 1);
  localparam int c_DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

  // Button index 0 is mode, index 1 is inc
  logic [1:0] w_btn_raw;
  logic [1:0] w_press;
  assign w_btn_raw = {btn_inc, btn_mode};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic              r_sync0;
    logic              r_sync1;
    logic              r_db;
    logic              r_db_q;
    logic [c_DB_W-1:0] r_cnt;

    // Synchronise, require DEBOUNCE_TICKS differing samples before accepting a new level
    always_ff @(posedge clk_1000hz or negedge rst_n) begin
      if (!rst_n) begin
        r_sync0 <= 1'b0;
        r_sync1 <= 1'b0;
        r_db    <= 1'b0;
        r_db_q  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync0 <= w_btn_raw[gi];
        r_sync1 <= r_sync0;
        r_db_q  <= r_db;
        if (r_sync1 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_db  <= r_sync1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    // Press is the debounced rising edge only; releases produce nothing
    assign w_press[gi] = r_db & ~r_db_q;
  end

  logic w_mode_press;
  logic w_inc_press;
  assign w_mode_press = w_press[0];
  assign w_inc_press  = w_press[1];

  state_t                r_state;
  logic [c_PRESC_W-1:0]  r_presc;
  logic [5:0]            r_sec;
  logic [5:0]            r_min;
  logic [5:0]            r_hour;
  logic                  r_tick;

  logic w_presc_end;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hour_wrap;
  assign w_presc_end = (r_presc == c_PRESC_MAX);
  assign w_sec_wrap  = (r_sec  == 6'd59);
  assign w_min_wrap  = (r_min  == 6'd59);
  assign w_hour_wrap = (r_hour == 6'd23);

  // Mode FSM, prescaler and the sec/min/hour carry chain; a mode press overrides inc
  always_ff @(posedge clk_1000hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_presc <= '0;
      r_sec   <= 6'd0;
      r_min   <= 6'd0;
      r_hour  <= 6'd0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_mode_press) begin
            r_state <= ST_SET_HOUR;
          end else if (w_presc_end) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
            if (w_sec_wrap) begin
              r_sec <= 6'd0;
              if (w_min_wrap) begin
                r_min  <= 6'd0;
                r_hour <= w_hour_wrap ? 6'd0 : r_hour + 6'd1;
              end else begin
                r_min <= r_min + 6'd1;
              end
            end else begin
              r_sec <= r_sec + 6'd1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        ST_SET_HOUR: begin
          if (w_mode_press) begin
            r_state <= ST_SET_MIN;
          end else if (w_inc_press) begin
            r_hour <= w_hour_wrap ? 6'd0 : r_hour + 6'd1;
          end
        end
        ST_SET_MIN: begin
          if (w_mode_press) begin
            // Restart the second so the first tick is a full second away
            r_state <= ST_RUN;
            r_sec   <= 6'd0;
            r_presc <= '0;
          end else if (w_inc_press) begin
            r_min <= w_min_wrap ? 6'd0 : r_min + 6'd1;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign sec       = r_sec;
  assign min       = r_min;
  assign hour      = r_hour;
  assign set_state = r_state;
  assign tick_1hz  = r_tick;

`ifdef HOURLY_CHIME_EN
  localparam int c_CHIME_W = (CHIME_TICKS > 1) ? $clog2(CHIME_TICKS) : 1;
  localparam logic [c_CHIME_W-1:0] c_CHIME_LAST = c_CHIME_W'(CHIME_TICKS - 1);

  logic                 r_chime;
  logic [c_CHIME_W-1:0] r_chime_cnt;
  logic                 w_hour_carry;
  logic                 w_enter_set;

  // Only a running rollover to MM:SS = 00:00 counts; manual setting never chimes
  assign w_hour_carry = (r_state == ST_RUN) && !w_mode_press && w_presc_end
                        && w_sec_wrap && w_min_wrap;
  assign w_enter_set  = (r_state == ST_RUN) && w_mode_press;

  // Chime pulse: CHIME_TICKS cycles long, cut short on entry to SET_HOUR
  always_ff @(posedge clk_1000hz or negedge rst_n) begin
    if (!rst_n) begin
      r_chime     <= 1'b0;
      r_chime_cnt <= '0;
    end else if (w_enter_set) begin
      r_chime     <= 1'b0;
      r_chime_cnt <= '0;
    end else if (w_hour_carry) begin
      r_chime     <= 1'b1;
      r_chime_cnt <= c_CHIME_LAST;
    end else if (r_chime) begin
      if (r_chime_cnt == '0) begin
        r_chime <= 1'b0;
      end else begin
        r_chime_cnt <= r_chime_cnt - 1'b1;
      end
    end
  end

  assign chime = r_chime;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_time_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_time_keeper
// Description : Directed bench for clock_time_keeper. Stimulus pushes the
//               expected {set_state,hour,min,sec} for every change it causes;
//               a monitor pops and compares whenever the DUT's time/state moves.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_time_keeper;

  logic       clk_1000hz = 1'b0;
  logic       rst_n      = 1'b0;
  logic       btn_mode   = 1'b0;
  logic       btn_inc    = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hour;
  logic [1:0] set_state;
  logic       tick_1hz;
`ifdef HOURLY_CHIME_EN
  logic       chime;
`endif

  clock_time_keeper dut (
    .clk_1000hz (clk_1000hz),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .sec        (sec),
    .min        (min),
    .hour       (hour),
    .set_state  (set_state),
    .tick_1hz   (tick_1hz)
`ifdef HOURLY_CHIME_EN
    ,
    .chime      (chime)
`endif
  );

  always #5 clk_1000hz = ~clk_1000hz;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [19:0] exp_q[$];
  bit          mon_en   = 1'b0;
  int          est = 0, eh = 0, em = 0, es = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back({2'(est), 6'(eh), 6'(em), 6'(es)});
  endtask

  // Scoreboard monitor: every change of the observed tuple must match the next expectation
  initial begin : monitor
    logic [19:0] prev;
    logic [19:0] obs;
    logic [19:0] e;
    logic        prev_tick;
    wait (mon_en);
    @(negedge clk_1000hz);
    prev      = {set_state, hour, min, sec};
    prev_tick = tick_1hz;
    forever begin
      @(negedge clk_1000hz);
      obs = {set_state, hour, min, sec};
      if (obs !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got st=%0d %0d:%0d:%0d with nothing expected",
                   obs[19:18], obs[17:12], obs[11:6], obs[5:0]);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL sb_time: got st=%0d %0d:%0d:%0d, expected st=%0d %0d:%0d:%0d",
                     obs[19:18], obs[17:12], obs[11:6], obs[5:0],
                     e[19:18], e[17:12], e[11:6], e[5:0]);
          end
        end
      end
      if (prev_tick) chk("tick_width", int'(tick_1hz), 0);
      if (tick_1hz)  chk("tick_in_run", int'(set_state), 0);
      prev      = obs;
      prev_tick = tick_1hz;
    end
  end

  task automatic press(input bit m, input bit i);
    @(posedge clk_1000hz); #1;
    btn_mode = m;
    btn_inc  = i;
    repeat (25) @(posedge clk_1000hz);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (25) @(posedge clk_1000hz);
  endtask

  // Counts cycles from the current point until tick_1hz is seen (bounded)
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk_1000hz);
      @(negedge clk_1000hz);
      n++;
    end while (!tick_1hz && n < 1100);
  endtask

  // Press mode from SET_MIN and return at the negedge where RUN is first visible
  task automatic mode_to_run();
    int n;
    n = 0;
    @(posedge clk_1000hz); #1;
    btn_mode = 1'b1;
    do begin
      @(negedge clk_1000hz);
      n++;
    end while (set_state != 2'b00 && n < 60);
    chk("mode_press_latency_ok", (n <= 24) ? 1 : 0, 1);
    btn_mode = 1'b0;
  endtask

  task automatic advance_model();
    es++;
    if (es == 60) begin
      es = 0;
      em++;
      if (em == 60) begin
        em = 0;
        eh = (eh == 23) ? 0 : eh + 1;
      end
    end
  endtask

  initial begin : watchdog
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;

    // Reset state
    repeat (5) @(posedge clk_1000hz);
    @(negedge clk_1000hz);
    chk("rst_sec", int'(sec), 0);
    chk("rst_min", int'(min), 0);
    chk("rst_hour", int'(hour), 0);
    chk("rst_state", int'(set_state), 0);
    chk("rst_tick", int'(tick_1hz), 0);
`ifdef HOURLY_CHIME_EN
    chk("rst_chime", int'(chime), 0);
`endif
    @(posedge clk_1000hz); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // First tick 1000 cycles after release
    es = 1;
    push_exp();
    wait_tick(n);
    chk("first_tick_cycle", n, 1000);

    // Set flow: hour +25 wraps to 1, min +3, back to RUN with sec cleared
    est = 1; push_exp();
    press(1'b1, 1'b0);
    for (int i = 0; i < 25; i++) begin
      eh = (eh == 23) ? 0 : eh + 1;
      push_exp();
      press(1'b0, 1'b1);
    end
    chk("hour_wrap_to_1", int'(hour), 1);
    est = 2; push_exp();
    press(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      em++;
      push_exp();
      press(1'b0, 1'b1);
    end
    chk("min_after_3", int'(min), 3);
    chk("sec_frozen", int'(sec), 1);
    est = 0; es = 0; push_exp();
    mode_to_run();
    es = 1; push_exp();
    wait_tick(n);
    chk("tick_after_set", n, 1000);

    // inc in RUN is ignored
    press(1'b0, 1'b1);

    // Simultaneous press in SET_HOUR: mode wins
    est = 1; push_exp();
    press(1'b1, 1'b0);
    est = 2; push_exp();
    press(1'b1, 1'b1);
    chk("simul_hour_unchanged", int'(hour), 1);
    chk("simul_state", int'(set_state), 2);

    // Bouncing inc in SET_MIN gives nothing; stable 30-cycle high gives one step
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_1000hz); #1; btn_inc = 1'b1;
      repeat (4) @(posedge clk_1000hz);
      #1; btn_inc = 1'b0;
      repeat (4) @(posedge clk_1000hz);
    end
    repeat (25) @(posedge clk_1000hz);
    chk("bounce_min", int'(min), 3);
    em = 4; push_exp();
    @(posedge clk_1000hz); #1; btn_inc = 1'b1;
    repeat (30) @(posedge clk_1000hz);
    #1; btn_inc = 1'b0;
    repeat (30) @(posedge clk_1000hz);
    chk("stable_min", int'(min), 4);

    // Set 23:59 and run through midnight
    for (int i = 0; i < 55; i++) begin
      em++;
      push_exp();
      press(1'b0, 1'b1);
    end
    est = 0; es = 0; push_exp();
    press(1'b1, 1'b0);
    est = 1; push_exp();
    press(1'b1, 1'b0);
    for (int i = 0; i < 22; i++) begin
      eh++;
      push_exp();
      press(1'b0, 1'b1);
    end
    est = 2; push_exp();
    press(1'b1, 1'b0);
    chk("preset_hour", int'(hour), 23);
    chk("preset_min", int'(min), 59);
    est = 0; push_exp();
    mode_to_run();
    for (int i = 0; i < 60; i++) begin
      advance_model();
      push_exp();
      wait_tick(n);
      chk("tick_interval", n, 1000);
`ifdef HOURLY_CHIME_EN
      chk("chime_at_tick", int'(chime), (i == 59) ? 1 : 0);
`endif
    end
    chk("midnight_hour", int'(hour), 0);
    chk("midnight_min", int'(min), 0);
    chk("midnight_sec", int'(sec), 0);
`ifdef HOURLY_CHIME_EN
    n = 1;
    begin : chime_len
      for (int k = 0; k < 700; k++) begin
        @(posedge clk_1000hz);
        @(negedge clk_1000hz);
        if (!chime) disable chime_len;
        n++;
      end
    end
    chk("chime_length", n, 500);
`endif

    // Async reset in SET_MIN with min=42
    est = 1; push_exp();
    press(1'b1, 1'b0);
    est = 2; push_exp();
    press(1'b1, 1'b0);
    for (int i = 0; i < 42; i++) begin
      em++;
      push_exp();
      press(1'b0, 1'b1);
    end
    chk("pre_reset_min", int'(min), 42);
    est = 0; eh = 0; em = 0; es = 0; push_exp();
    @(posedge clk_1000hz); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_min", int'(min), 0);
    chk("async_rst_state", int'(set_state), 0);
    chk("async_rst_hour", int'(hour), 0);
    repeat (3) @(posedge clk_1000hz);
    #1; rst_n = 1'b1;
    repeat (5) @(posedge clk_1000hz);
    @(negedge clk_1000hz);
    @(negedge clk_1000hz);
    chk("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
